// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch unit:
//   - default geometry (instruction width, program memory depth, prefetch
//     queue depth) used as parameter defaults by instr_fetch_unit
//   - FSM state encoding for the fetch controller
package fetch_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_MEM_DEPTH   = 8;
    localparam int DEF_QUEUE_DEPTH = 2;

    // Fetch controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;  // PC has caught up with loaded words
    localparam logic [1:0] ST_FETCH = 2'd1;  // issuing reads from program memory
    localparam logic [1:0] ST_FLUSH = 2'd2;  // one-cycle redirect, no issue

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
// Synchronous FIFO holding prefetched {word, tag} pairs.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   clear_i           synchronous clear (empties the queue, ignores push)
//   push_i            push {push_word_i, push_tag_i}
//   pop_i             pop the head entry (ignored when empty)
//   head_word_o/tag_o head entry contents (meaningful when !empty_o)
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries
// Push on a full queue is accepted when a pop happens in the same cycle.
module fetch_queue #(
    parameter  int WORD_W = 32,
    parameter  int TAG_W  = 3,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_word_i,
    input  logic [TAG_W-1:0]  push_tag_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] head_word_o,
    output logic [TAG_W-1:0]  head_tag_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [WORD_W+TAG_W-1:0] slots_q [DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    do_push, do_pop;

    // Pointer increment with explicit wrap so DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign {head_word_o, head_tag_o} = slots_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; entries are only observed once pushed.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            slots_q[wr_ptr_q] <= {push_word_i, push_tag_i};
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Loadable program memory with a prefetching fetch engine feeding a
// valid/ready consumer.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_write_enable           write i_load_instruction to mem[i_load_address]
//   i_load_address/instr.    write address / data
//   i_flush, i_redirect_pc   discard prefetched words and restart at redirect
//   i_ready                  consumer accepts the head word
//   o_valid, o_instruction   head word present / head word
//   o_pc                     address of the head word
//   o_avail                  loaded high-water mark (highest address + 1)
//   o_debug_flag             toggles on every accepted transfer
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter  int DATA_W      = DEF_DATA_W,
    parameter  int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter  int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    localparam int ADDR_W      = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_write_enable,
    input  logic [ADDR_W-1:0] i_load_address,
    input  logic [DATA_W-1:0] i_load_instruction,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instruction,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W:0]   o_avail,
    output logic              o_debug_flag
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    // Program memory with registered read port
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] tag_q;

    // PC and high-water mark are one bit wider so they can reach MEM_DEPTH
    logic [ADDR_W:0]   pc_q, pc_d;
    logic [ADDR_W:0]   avail_q, avail_d;
    logic [ADDR_W:0]   load_end;
    logic [1:0]        state_q, state_d;
    logic              inflight_q, inflight_d;
    logic              flag_q, flag_d;

    logic              q_full, q_empty;
    logic [CNT_W-1:0]  q_count;
    logic [DATA_W-1:0] q_head_word;
    logic [ADDR_W-1:0] q_head_tag;

    logic              xfer;
    logic              issue;
    logic [OCC_W-1:0]  occupancy;

    assign xfer = !q_empty && i_ready;

    // Slots claimed after this edge: stored words plus the read in flight,
    // minus the word the consumer takes now. Crediting the pop keeps one
    // word per cycle flowing with a two-entry queue.
    assign occupancy = OCC_W'(q_count) + OCC_W'(inflight_q) - OCC_W'(xfer);

    assign issue = (state_q == ST_FETCH) && !i_flush && (pc_q < avail_q)
                && (occupancy < OCC_W'(QUEUE_DEPTH)) && (!q_full || xfer);

    assign load_end = {1'b0, i_load_address} + (ADDR_W + 1)'(1);

    always_comb begin
        pc_d       = pc_q;
        avail_d    = avail_q;
        state_d    = state_q;
        inflight_d = issue;
        flag_d     = flag_q ^ xfer;

        if (i_write_enable && (load_end > avail_q)) begin
            avail_d = load_end;
        end

        if (i_flush) begin
            pc_d       = {1'b0, i_redirect_pc};
            inflight_d = 1'b0;
        end else if (issue) begin
            pc_d = pc_q + (ADDR_W + 1)'(1);
        end

        // Every non-flush state resolves to FETCH or IDLE purely on whether
        // the (possibly incremented or redirected) PC is below the mark.
        if (i_flush) begin
            state_d = ST_FLUSH;
        end else if (pc_d < avail_q) begin
            state_d = ST_FETCH;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            avail_q    <= '0;
            state_q    <= ST_IDLE;
            inflight_q <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            avail_q    <= avail_d;
            state_q    <= state_d;
            inflight_q <= inflight_d;
            flag_q     <= flag_d;
        end
    end

    // Read and write in one process: a same-address write in the issue
    // cycle returns the old word.
    always_ff @(posedge clk) begin
        if (issue) begin
            rdata_q <= mem_q[pc_q[ADDR_W-1:0]];
            tag_q   <= pc_q[ADDR_W-1:0];
        end
        if (i_write_enable) begin
            mem_q[i_load_address] <= i_load_instruction;
        end
    end

    fetch_queue #(
        .WORD_W (DATA_W),
        .TAG_W  (ADDR_W),
        .DEPTH  (QUEUE_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (i_flush),
        .push_i      (inflight_q && !i_flush),
        .push_word_i (rdata_q),
        .push_tag_i  (tag_q),
        .pop_i       (xfer),
        .head_word_o (q_head_word),
        .head_tag_o  (q_head_tag),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    // Outputs read zero when nothing is queued, which also gives the reset values.
    assign o_valid       = !q_empty;
    assign o_instruction = q_empty ? '0 : q_head_word;
    assign o_pc          = q_empty ? '0 : q_head_tag;
    assign o_avail       = avail_q;
    assign o_debug_flag  = flag_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int DATA_W      = 32;
    localparam int MEM_DEPTH   = 8;
    localparam int QUEUE_DEPTH = 2;
    localparam int ADDR_W      = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_write_enable = 1'b0;
    logic [ADDR_W-1:0] i_load_address = '0;
    logic [DATA_W-1:0] i_load_instruction = '0;
    logic              i_flush = 1'b0;
    logic [ADDR_W-1:0] i_redirect_pc = '0;
    logic              i_ready = 1'b0;
    logic              o_valid;
    logic [DATA_W-1:0] o_instruction;
    logic [ADDR_W-1:0] o_pc;
    logic [ADDR_W:0]   o_avail;
    logic              o_debug_flag;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DATA_W      (DATA_W),
        .MEM_DEPTH   (MEM_DEPTH),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_write_enable     (i_write_enable),
        .i_load_address     (i_load_address),
        .i_load_instruction (i_load_instruction),
        .i_flush            (i_flush),
        .i_redirect_pc      (i_redirect_pc),
        .i_ready            (i_ready),
        .o_valid            (o_valid),
        .o_instruction      (o_instruction),
        .o_pc               (o_pc),
        .o_avail            (o_avail),
        .o_debug_flag       (o_debug_flag)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: program memory image, high-water mark, the address
    // the consumer should see next, and the transfer-parity flag.
    logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
    int                ref_avail   = 0;
    int                ref_next_pc = 0;
    int                ref_xfers   = 0;
    logic              ref_flag    = 1'b0;
    logic              prev_flush  = 1'b0;
    logic              prev_hold   = 1'b0;
    logic [ADDR_W-1:0] prev_pc     = '0;
    logic [DATA_W-1:0] prev_instr  = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one clock cycle, check outputs against the model mid-cycle,
    // then advance the model to reflect the coming edge.
    task automatic drive_cycle(input logic we, input int addr, input logic [DATA_W-1:0] data,
                               input logic fl, input int redir, input logic rdy);
        logic [ADDR_W-1:0] a;
        a = addr[ADDR_W-1:0];
        i_write_enable     = we;
        i_load_address     = a;
        i_load_instruction = data;
        i_flush            = fl;
        i_redirect_pc      = redir[ADDR_W-1:0];
        i_ready            = rdy;
        @(negedge clk);
        check_eq("avail", 64'(o_avail), 64'(ref_avail));
        check_eq("debug_flag", 64'(o_debug_flag), 64'(ref_flag));
        if (prev_flush) begin
            check_eq("valid_after_flush", 64'(o_valid), 64'(0));
        end
        if (prev_hold) begin
            check_eq("hold_valid", 64'(o_valid), 64'(1));
            check_eq("hold_pc", 64'(o_pc), 64'(prev_pc));
            check_eq("hold_instr", 64'(o_instruction), 64'(prev_instr));
        end
        if (o_valid) begin
            check_eq("pc_expected", 64'(ref_next_pc < ref_avail), 64'(1));
            check_eq("pc", 64'(o_pc), 64'(ref_next_pc));
            if (ref_next_pc >= 0 && ref_next_pc < MEM_DEPTH) begin
                check_eq("instr", 64'(o_instruction), 64'(ref_mem[ref_next_pc]));
            end
        end
        prev_hold  = o_valid && !rdy && !fl;
        prev_pc    = o_pc;
        prev_instr = o_instruction;
        if (o_valid && rdy) begin
            $display("xfer %0d: pc=%0d instr=0x%08h", ref_xfers, o_pc, o_instruction);
            ref_next_pc++;
            ref_xfers++;
            ref_flag = ~ref_flag;
        end
        if (fl) begin
            ref_next_pc = int'(redir[ADDR_W-1:0]);
        end
        prev_flush = fl;
        if (we) begin
            ref_mem[a] = data;
            if (int'(a) + 1 > ref_avail) begin
                ref_avail = int'(a) + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic rdy);
        drive_cycle(1'b0, 0, '0, 1'b0, 0, rdy);
    endtask

    task automatic model_reset();
        ref_avail   = 0;
        ref_next_pc = 0;
        ref_flag    = 1'b0;
        prev_flush  = 1'b0;
        prev_hold   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 64'(o_valid), 64'(0));
        check_eq({tag, "_instr"}, 64'(o_instruction), 64'(0));
        check_eq({tag, "_pc"}, 64'(o_pc), 64'(0));
        check_eq({tag, "_avail"}, 64'(o_avail), 64'(0));
        check_eq({tag, "_flag"}, 64'(o_debug_flag), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_write_enable = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    // Run with i_ready=1 until the model expects nothing more and the DUT is empty
    task automatic drain(input int budget);
        int n = 0;
        while ((ref_next_pc < ref_avail || o_valid) && n < budget) begin
            idle_cycle(1'b1);
            n++;
        end
        check_eq("drain_done", 64'(ref_next_pc >= ref_avail && !o_valid), 64'(1));
    endtask

    task automatic load4(input logic rdy);
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, k, DATA_W'(32'hA0 + k), 1'b0, 0, rdy);
        end
    endtask

    initial begin
        int base;
        for (int a = 0; a < MEM_DEPTH; a++) ref_mem[a] = '0;
        do_reset();

        // Fill every word so later streams never depend on unwritten memory
        for (int a = 0; a < MEM_DEPTH; a++) begin
            drive_cycle(1'b1, a, DATA_W'($urandom), 1'b0, 0, 1'b1);
        end
        drain(60);

        // Streaming latency and throughput
        do_reset();
        drive_cycle(1'b1, 0, 32'hA0, 1'b0, 0, 1'b1);
        drive_cycle(1'b1, 1, 32'hA1, 1'b0, 0, 1'b1);
        drive_cycle(1'b1, 2, 32'hA2, 1'b0, 0, 1'b1);
        check_eq("lat_not_yet_valid", 64'(o_valid), 64'(0));
        drive_cycle(1'b1, 3, 32'hA3, 1'b0, 0, 1'b1);
        check_eq("lat_first_valid", 64'(o_valid), 64'(1));
        check_eq("lat_first_pc", 64'(o_pc), 64'(0));
        check_eq("lat_first_instr", 64'(o_instruction), 64'(32'hA0));
        for (int k = 1; k < 4; k++) begin
            idle_cycle(1'b1);
            check_eq("stream_valid", 64'(o_valid), 64'(1));
            check_eq("stream_pc", 64'(o_pc), 64'(k));
            check_eq("stream_instr", 64'(o_instruction), 64'(32'hA0 + k));
        end
        idle_cycle(1'b1);
        check_eq("stream_end_valid", 64'(o_valid), 64'(0));
        repeat (3) idle_cycle(1'b1);

        // Back-pressure: queue fills, PC stops, head held, then release
        do_reset();
        load4(1'b0);
        repeat (6) idle_cycle(1'b0);
        check_eq("bp_valid", 64'(o_valid), 64'(1));
        check_eq("bp_pc", 64'(o_pc), 64'(0));
        check_eq("bp_instr", 64'(o_instruction), 64'(32'hA0));
        check_eq("bp_occupancy", 64'(dut.q_count), 64'(2));
        check_eq("bp_pc_stop", 64'(dut.pc_q), 64'(2));
        base = ref_xfers;
        drain(40);
        check_eq("bp_xfer_count", 64'(ref_xfers - base), 64'(4));

        // Flush with a coinciding transfer, redirect to 1
        do_reset();
        load4(1'b0);
        repeat (3) idle_cycle(1'b0);
        base = ref_xfers;
        drive_cycle(1'b0, 0, '0, 1'b1, 1, 1'b1);
        check_eq("flush_gap_valid", 64'(o_valid), 64'(0));
        drain(40);
        check_eq("flush_xfer_count", 64'(ref_xfers - base), 64'(4));
        // Back-to-back flushes: the last redirect wins
        drive_cycle(1'b0, 0, '0, 1'b1, 3, 1'b1);
        drive_cycle(1'b0, 0, '0, 1'b1, 2, 1'b1);
        base = ref_xfers;
        drain(40);
        check_eq("flush2_xfer_count", 64'(ref_xfers - base), 64'(2));

        // Write extending the mark while stalled resumes with the new word
        do_reset();
        for (int k = 0; k < 5; k++) drive_cycle(1'b1, k, DATA_W'($urandom), 1'b0, 0, 1'b1);
        drain(40);
        check_eq("resume_avail5", 64'(o_avail), 64'(5));
        drive_cycle(1'b1, 5, 32'hC0DE_0005, 1'b0, 0, 1'b1);
        base = ref_xfers;
        drain(40);
        check_eq("resume_avail6", 64'(o_avail), 64'(6));
        check_eq("resume_xfer_count", 64'(ref_xfers - base), 64'(1));
        check_eq("resume_last_word", 64'(prev_instr), 64'(32'hC0DE_0005));

        // Top address only: runs 0..7 with no wrap
        do_reset();
        drive_cycle(1'b1, 7, DATA_W'($urandom), 1'b0, 0, 1'b1);
        base = ref_xfers;
        drain(60);
        check_eq("top_avail", 64'(o_avail), 64'(8));
        check_eq("top_xfer_count", 64'(ref_xfers - base), 64'(8));
        repeat (5) idle_cycle(1'b1);
        check_eq("top_no_wrap", 64'(o_valid), 64'(0));

        // Reset during an in-flight read
        do_reset();
        load4(1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        repeat (8) idle_cycle(1'b1);
        check_eq("midreset_quiet", 64'(o_valid), 64'(0));
        base = ref_xfers;
        drive_cycle(1'b1, 0, DATA_W'($urandom), 1'b0, 0, 1'b1);
        drive_cycle(1'b1, 1, DATA_W'($urandom), 1'b0, 0, 1'b1);
        drain(40);
        check_eq("midreset_reload", 64'(ref_xfers - base), 64'(2));

        // Randomized traffic: back-pressure, extending writes, flushes, resets
        for (int round = 0; round < 6; round++) begin
            do_reset();
            for (int c = 0; c < 120; c++) begin
                logic we, fl, rdy;
                int   addr;
                rdy  = ($urandom_range(0, 3) != 0);
                we   = (ref_avail < MEM_DEPTH) && ($urandom_range(0, 3) == 0);
                addr = we ? ref_avail + int'($urandom_range(0, MEM_DEPTH - 1 - ref_avail)) : 0;
                fl   = ($urandom_range(0, 19) == 0);
                drive_cycle(we, addr, DATA_W'($urandom), fl,
                            int'($urandom_range(0, MEM_DEPTH - 1)), rdy);
            end
            drain(60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
